voice_allocator: RTL and testbench



---
 rtl/synth_pkg.sv | 21 ++
 rtl/voice_envelope.sv | 68 ++++++
 rtl/voice_allocator.sv | 172 +++++++++++++++++
 tb/tb_voice_allocator.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/synth_pkg.sv
// Shared types and constants for the voice allocator and its per-voice envelopes.
package synth_pkg;

    typedef enum logic [1:0] {
        V_IDLE,
        V_ATTACK,
        V_SUSTAIN,
        V_RELEASE
    } voice_state_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SCAN,
        S_APPLY
    } ev_fsm_t;

    localparam logic [15:0] MAX_LEVEL        = 16'hFFFF;
    localparam logic [15:0] ATTACK_STEP_DEF  = 16'd2048;
    localparam logic [15:0] RELEASE_STEP_DEF = 16'd512;

endpackage

// File: rtl/voice_envelope.sv
// One voice's attack/sustain/release level ramp; start commands override the tick.
module voice_envelope
    import synth_pkg::*;
#(
    parameter logic [15:0] ATTACK_STEP  = ATTACK_STEP_DEF,
    parameter logic [15:0] RELEASE_STEP = RELEASE_STEP_DEF
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         tick,
    input  logic         start_attack,
    input  logic         start_release,
    output voice_state_t state_o,
    output logic [15:0]  level_o,
    output logic         done_o
);

    voice_state_t state_q, state_d;
    logic [15:0]  level_q, level_d;
    logic [16:0]  up;

    always_comb begin
        state_d = state_q;
        level_d = level_q;
        done_o  = 1'b0;
        up      = {1'b0, level_q} + {1'b0, ATTACK_STEP};
        if (start_attack) begin
            state_d = V_ATTACK;
        end else if (start_release) begin
            state_d = V_RELEASE;
        end else if (tick) begin
            case (state_q)
                V_ATTACK: begin
                    if (up >= {1'b0, MAX_LEVEL}) begin
                        level_d = MAX_LEVEL;
                        state_d = V_SUSTAIN;
                    end else begin
                        level_d = up[15:0];
                    end
                end
                V_RELEASE: begin
                    if (level_q <= RELEASE_STEP) begin
                        level_d = '0;
                        state_d = V_IDLE;
                        done_o  = 1'b1;
                    end else begin
                        level_d = level_q - RELEASE_STEP;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= V_IDLE;
            level_q <= '0;
        end else begin
            state_q <= state_d;
            level_q <= level_d;
        end
    end

    assign state_o = state_q;
    assign level_o = level_q;

endmodule

// File: rtl/voice_allocator.sv
// Event-driven voice scheduler: serial scan of voice slots, then a one-cycle apply
// of note-on (retrigger / idle / oldest release / steal) or note-off.
module voice_allocator
    import synth_pkg::*;
#(
    parameter int          VOICES       = 8,
    parameter logic [15:0] ATTACK_STEP  = ATTACK_STEP_DEF,
    parameter logic [15:0] RELEASE_STEP = RELEASE_STEP_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    ev_valid,
    output logic                    ev_ready,
    input  logic                    ev_on,
    input  logic [7:0]              ev_note,
    input  logic [31:0]             ev_freq,
    input  logic                    env_tick,
    output logic [VOICES-1:0][31:0] frequencies,
    output logic [VOICES-1:0][31:0] voice_volumes,
    output logic [VOICES-1:0]       voice_active
);

    localparam int IW = (VOICES > 1) ? $clog2(VOICES) : 1;

    ev_fsm_t fsm_q, fsm_d;
    logic                    ready_q;
    logic [IW-1:0]           idx_q;
    logic                    ev_on_q;
    logic [7:0]              ev_note_q;
    logic [31:0]             ev_freq_q;

    logic [VOICES-1:0][7:0]    note_q;
    logic [VOICES-1:0][31:0]   freq_q;
    logic [VOICES-1:0][IW-1:0] age_q;

    // Scan results gathered one voice per cycle
    logic                retrig_hit_q, idle_hit_q, rel_hit_q;
    logic [IW-1:0]       retrig_idx_q, idle_idx_q, rel_idx_q, rel_age_q, old_idx_q;
    logic [VOICES-1:0]   off_mask_q;

    voice_state_t        vstate [VOICES];
    logic [15:0]         vlevel [VOICES];
    logic [VOICES-1:0]   vdone, start_atk, start_rel;

    voice_state_t        scan_st;
    logic [IW-1:0]       scan_age, tgt_idx;
    logic                scan_busy_match, accept;

    assign accept          = (fsm_q == S_IDLE) && ready_q && ev_valid;
    assign scan_st         = vstate[idx_q];
    assign scan_age        = age_q[idx_q];
    assign scan_busy_match = ((scan_st == V_ATTACK) || (scan_st == V_SUSTAIN))
                             && (note_q[idx_q] == ev_note_q);

    always_comb begin
        fsm_d = fsm_q;
        case (fsm_q)
            S_IDLE:  if (accept) fsm_d = S_SCAN;
            S_SCAN:  if (idx_q == IW'(VOICES - 1)) fsm_d = S_APPLY;
            S_APPLY: fsm_d = S_IDLE;
            default: fsm_d = S_IDLE;
        endcase
    end

    always_comb begin
        if (retrig_hit_q)     tgt_idx = retrig_idx_q;
        else if (idle_hit_q)  tgt_idx = idle_idx_q;
        else if (rel_hit_q)   tgt_idx = rel_idx_q;
        else                  tgt_idx = old_idx_q;
        start_atk = '0;
        start_rel = '0;
        if (fsm_q == S_APPLY) begin
            if (ev_on_q) start_atk[tgt_idx] = 1'b1;
            else         start_rel          = off_mask_q;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            fsm_q        <= S_IDLE;
            ready_q      <= 1'b0;
            idx_q        <= '0;
            ev_on_q      <= 1'b0;
            ev_note_q    <= '0;
            ev_freq_q    <= '0;
            note_q       <= '0;
            freq_q       <= '0;
            retrig_hit_q <= 1'b0;
            idle_hit_q   <= 1'b0;
            rel_hit_q    <= 1'b0;
            retrig_idx_q <= '0;
            idle_idx_q   <= '0;
            rel_idx_q    <= '0;
            rel_age_q    <= '0;
            old_idx_q    <= '0;
            off_mask_q   <= '0;
            for (int v = 0; v < VOICES; v++) age_q[v] <= IW'(v);
        end else begin
            fsm_q   <= fsm_d;
            ready_q <= (fsm_d == S_IDLE);
            case (fsm_q)
                S_IDLE: if (accept) begin
                    ev_on_q      <= ev_on;
                    ev_note_q    <= ev_note;
                    ev_freq_q    <= ev_freq;
                    idx_q        <= '0;
                    retrig_hit_q <= 1'b0;
                    idle_hit_q   <= 1'b0;
                    rel_hit_q    <= 1'b0;
                    off_mask_q   <= '0;
                end
                S_SCAN: begin
                    idx_q <= idx_q + 1'b1;
                    if (scan_busy_match) begin
                        off_mask_q[idx_q] <= 1'b1;
                        if (!retrig_hit_q) begin
                            retrig_hit_q <= 1'b1;
                            retrig_idx_q <= idx_q;
                        end
                    end
                    if (scan_st == V_IDLE && !idle_hit_q) begin
                        idle_hit_q <= 1'b1;
                        idle_idx_q <= idx_q;
                    end
                    if (scan_st == V_RELEASE && (!rel_hit_q || scan_age > rel_age_q)) begin
                        rel_hit_q <= 1'b1;
                        rel_idx_q <= idx_q;
                        rel_age_q <= scan_age;
                    end
                    if (scan_age == IW'(VOICES - 1)) old_idx_q <= idx_q;
                end
                S_APPLY: if (ev_on_q) begin
                    for (int v = 0; v < VOICES; v++)
                        if (age_q[v] < age_q[tgt_idx]) age_q[v] <= age_q[v] + 1'b1;
                    age_q[tgt_idx] <= '0;
                end
                default: ;
            endcase
            for (int v = 0; v < VOICES; v++) begin
                if (start_atk[v]) begin
                    note_q[v] <= ev_note_q;
                    freq_q[v] <= ev_freq_q;
                end else if (vdone[v]) begin
                    note_q[v] <= '0;
                    freq_q[v] <= '0;
                end
            end
        end
    end

    for (genvar g = 0; g < VOICES; g++) begin : g_voice
        voice_envelope #(
            .ATTACK_STEP (ATTACK_STEP),
            .RELEASE_STEP(RELEASE_STEP)
        ) u_env (
            .clk          (clk),
            .reset        (reset),
            .tick         (env_tick),
            .start_attack (start_atk[g]),
            .start_release(start_rel[g]),
            .state_o      (vstate[g]),
            .level_o      (vlevel[g]),
            .done_o       (vdone[g])
        );
        assign voice_volumes[g] = {16'b0, vlevel[g]};
        assign voice_active[g]  = (vstate[g] != V_IDLE);
    end

    assign frequencies = freq_q;
    assign ev_ready    = ready_q;

endmodule

// File: tb/tb_voice_allocator.sv
// Scoreboarded bench: an event-level reference model predicts every cycle's outputs.
module tb_voice_allocator;

    localparam int V   = 8;
    localparam int AST = 2048;
    localparam int RST = 512;
    localparam int MI = 0, MA = 1, MS = 2, MR = 3;

    logic clk = 1'b0;
    logic reset = 1'b1, ev_valid = 1'b0, ev_on = 1'b0, env_tick = 1'b0;
    logic [7:0]  ev_note = '0;
    logic [31:0] ev_freq = '0;
    logic        ev_ready;
    logic [V-1:0][31:0] frequencies, voice_volumes;
    logic [V-1:0]       voice_active;

    voice_allocator #(.VOICES(V), .ATTACK_STEP(16'd2048), .RELEASE_STEP(16'd512)) dut (
        .clk(clk), .reset(reset), .ev_valid(ev_valid), .ev_ready(ev_ready),
        .ev_on(ev_on), .ev_note(ev_note), .ev_freq(ev_freq), .env_tick(env_tick),
        .frequencies(frequencies), .voice_volumes(voice_volumes), .voice_active(voice_active)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int                 cyc;
        logic [V-1:0][31:0] f;
        logic [V-1:0][31:0] vol;
        logic [V-1:0]       act;
        logic               rdy;
    } snap_t;
    snap_t expq[$];

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: voice table plus a simple busy counter for the handshake
    int          m_st [V];
    int          m_lvl[V];
    int          m_age[V];
    logic [7:0]  m_note[V];
    logic [31:0] m_freq[V];
    bit          m_ready, m_busy;
    int          m_cnt;
    logic        e_on;
    logic [7:0]  e_note;
    logic [31:0] e_freq;

    task automatic env_step(input int i);
        if (m_st[i] == MA) begin
            m_lvl[i] = (m_lvl[i] + AST > 65535) ? 65535 : m_lvl[i] + AST;
            if (m_lvl[i] == 65535) m_st[i] = MS;
        end else if (m_st[i] == MR) begin
            m_lvl[i] = (m_lvl[i] < RST) ? 0 : m_lvl[i] - RST;
            if (m_lvl[i] == 0) begin
                m_st[i] = MI; m_note[i] = 0; m_freq[i] = 0;
            end
        end
    endtask

    task automatic model_edge(input logic r, input logic t, input logic v, input logic on,
                              input logic [7:0] n, input logic [31:0] f);
        bit tgt[V];
        int target, best, a;
        if (r) begin
            for (int i = 0; i < V; i++) begin
                m_st[i] = MI; m_lvl[i] = 0; m_note[i] = 0; m_freq[i] = 0; m_age[i] = i;
            end
            m_ready = 0; m_busy = 0; m_cnt = 0;
            return;
        end
        for (int i = 0; i < V; i++) tgt[i] = 0;
        target = -1;
        if (!m_busy) begin
            if (m_ready && v) begin
                m_busy = 1; m_cnt = 0; m_ready = 0;
                e_on = on; e_note = n; e_freq = f;
            end else begin
                m_ready = 1;
            end
        end else begin
            m_cnt++;
            if (m_cnt == V + 1) begin
                m_busy = 0; m_ready = 1;
                if (e_on) begin
                    for (int i = 0; i < V; i++)
                        if (target < 0 && (m_st[i] == MA || m_st[i] == MS) && m_note[i] == e_note) target = i;
                    for (int i = 0; i < V; i++)
                        if (target < 0 && m_st[i] == MI) target = i;
                    if (target < 0) begin
                        best = -1;
                        for (int i = 0; i < V; i++)
                            if (m_st[i] == MR && (best < 0 || m_age[i] > m_age[best])) best = i;
                        target = best;
                    end
                    if (target < 0)
                        for (int i = 0; i < V; i++) if (m_age[i] == V - 1) target = i;
                    tgt[target] = 1;
                end else begin
                    for (int i = 0; i < V; i++)
                        if ((m_st[i] == MA || m_st[i] == MS) && m_note[i] == e_note) tgt[i] = 1;
                end
            end
        end
        for (int i = 0; i < V; i++) if (!tgt[i] && t) env_step(i);
        if (target >= 0) begin
            a = m_age[target];
            for (int i = 0; i < V; i++) if (m_age[i] < a) m_age[i]++;
            m_age[target] = 0;
            m_note[target] = e_note; m_freq[target] = e_freq; m_st[target] = MA;
        end else begin
            for (int i = 0; i < V; i++) if (tgt[i]) m_st[i] = MR;
        end
    endtask

    task automatic push_snap();
        snap_t s;
        s.cyc = cyc + 1;
        for (int i = 0; i < V; i++) begin
            s.f[i]   = m_freq[i];
            s.vol[i] = {16'b0, 16'(m_lvl[i])};
            s.act[i] = (m_st[i] != MI);
        end
        s.rdy = m_ready;
        expq.push_back(s);
    endtask

    task automatic cyc_drive(input logic r, input logic t, input logic v, input logic on,
                             input logic [7:0] n, input logic [31:0] f);
        reset = r; env_tick = t; ev_valid = v; ev_on = on; ev_note = n; ev_freq = f;
        model_edge(r, t, v, on, n, f);
        push_snap();
        @(posedge clk); #1;
    endtask

    // Free-running cycles; ticks are held off while the scan is in progress
    task automatic idle(input int n, input int pct);
        logic t, v;
        for (int k = 0; k < n; k++) begin
            t = ($urandom_range(99) < pct);
            if (m_busy && m_cnt < V) t = 1'b0;
            v = m_busy ? 1'($urandom_range(1)) : 1'b0;
            cyc_drive(1'b0, t, v, 1'($urandom_range(1)), 8'($urandom), $urandom);
        end
    endtask

    // Offer one event, then feed ignored garbage until the apply cycle
    task automatic send(input logic on, input logic [7:0] n, input logic [31:0] f, input logic atick);
        while (!m_ready) idle(1, 0);
        cyc_drive(1'b0, 1'b0, 1'b1, on, n, f);
        for (int k = 0; k < V; k++)
            cyc_drive(1'b0, 1'b0, 1'($urandom_range(1)), 1'($urandom_range(1)), 8'($urandom), $urandom);
        cyc_drive(1'b0, atick, 1'($urandom_range(1)), 1'($urandom_range(1)), 8'($urandom), $urandom);
    endtask

    task automatic reset_seq();
        cyc_drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
        cyc_drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
        idle(1, 0);
    endtask

    task automatic chk(input string name, input logic [V*32-1:0] got, input logic [V*32-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s cyc=%0d got=%h exp=%h", name, cyc, got, exp);
        end
    endtask

    // Monitor: compares the DUT against whichever prediction is due this cycle
    initial begin
        snap_t s;
        forever begin
            @(negedge clk);
            while (expq.size() > 0 && expq[0].cyc < cyc) begin
                s = expq.pop_front();
                chk("missed_snapshot", V*32'(s.cyc), V*32'(cyc));
            end
            if (expq.size() > 0 && expq[0].cyc == cyc) begin
                s = expq.pop_front();
                chk("frequencies", frequencies, s.f);
                chk("voice_volumes", voice_volumes, s.vol);
                chk("voice_active", (V*32)'(voice_active), (V*32)'(s.act));
                chk("ev_ready", (V*32)'(ev_ready), (V*32)'(s.rdy));
            end
        end
    end

    initial begin
        model_edge(1'b1, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
        @(posedge clk); #1;
        for (int k = 0; k < 3; k++) cyc_drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
        idle(2, 0);

        send(1'b1, 8'h1C, 32'd440, 1'b0);
        idle(34, 100);
        send(1'b0, 8'h1C, 32'd0, 1'b0);
        idle(132, 100);

        reset_seq();
        for (int i = 0; i < 9; i++) begin
            send(1'b1, 8'(8'h30 + i), 32'(1000 + i), 1'b0);
            idle(3, 100);
        end

        reset_seq();
        for (int i = 0; i < 8; i++) send(1'b1, 8'(40 + i), 32'(2000 + i), 1'b0);
        idle(5, 100);
        send(1'b0, 8'd43, 32'd0, 1'b0);
        send(1'b1, 8'd60, 32'd3000, 1'b0);
        idle(3, 100);

        reset_seq();
        send(1'b1, 8'h1C, 32'd440, 1'b0);
        idle(4, 100);
        send(1'b1, 8'h1C, 32'd880, 1'b0);
        idle(3, 100);
        send(1'b0, 8'h77, 32'd0, 1'b0);
        idle(2, 100);

        reset_seq();
        for (int i = 0; i < 8; i++) send(1'b1, 8'(50 + i), 32'(4000 + i), 1'b0);
        idle(4, 100);
        send(1'b0, 8'd52, 32'd0, 1'b1);
        idle(3, 100);

        while (!m_ready) idle(1, 0);
        cyc_drive(1'b0, 1'b0, 1'b1, 1'b1, 8'h55, 32'h1234);
        for (int k = 0; k < 3; k++) cyc_drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
        cyc_drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h0, 32'h0);
        idle(4, 50);

        reset_seq();
        for (int e = 0; e < 250; e++) begin
            idle($urandom_range(12), 75);
            send(1'($urandom_range(99) < 65), 8'($urandom_range(11)), $urandom, 1'($urandom_range(1)));
        end
        idle(6, 75);

        @(posedge clk); @(posedge clk); #1;
        chk("queue_drained", (V*32)'(expq.size()), '0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
